// File: rtl/lagd_pkg.sv
// Shared types and defaults for the LAGD run-time programmable region decoder.
package lagd_pkg;

  localparam int unsigned RegionAddrWidth = 48;
  localparam int unsigned RegionIdxWidth  = 4;
  localparam int unsigned RegionNumRules  = 8;

  typedef enum logic [1:0] {
    RegionFieldStart  = 2'd0,
    RegionFieldEnd    = 2'd1,
    RegionFieldIdx    = 2'd2,
    RegionFieldEnable = 2'd3
  } region_field_e;

  typedef struct packed {
    logic [RegionAddrWidth-1:0] start_addr;
    logic [RegionAddrWidth-1:0] end_addr;
    logic [RegionIdxWidth-1:0]  idx;
    logic                       en;
  } region_rule_t;

endpackage

// File: rtl/lagd_region_match.sv
// Combinational rule comparators and lowest-rule-wins priority encoder.
module lagd_region_match
  import lagd_pkg::*;
#(
  parameter int unsigned NumRules = RegionNumRules,
  localparam int unsigned RuleW   = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  region_rule_t               i_rules [NumRules],
  input  logic [RegionAddrWidth-1:0] i_addr,
  output logic                       o_hit,
  output logic [RuleW-1:0]           o_win_num,
  output region_rule_t               o_win_rule
);

  // NOTE: every output gets a default before the loop, otherwise a path
  // with no match would hold the old value and infer a latch.
  always_comb begin
    o_hit      = 1'b0;
    o_win_num  = '0;
    o_win_rule = '0;
    // Walk from the highest rule down so the lowest matching rule lands last.
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (i_rules[i].en &&
          (i_addr >= i_rules[i].start_addr) &&
          (i_addr <= i_rules[i].end_addr)) begin
        o_hit      = 1'b1;
        o_win_num  = RuleW'(i);
        o_win_rule = i_rules[i];
      end
    end
  end

endmodule

// File: rtl/lagd_region_decoder.sv
// Run-time programmable address-region decoder with lockable rule table.
// Optional LAGD_REGION_OFFSET_EN adds rsp_offset_o (address minus matched start).
module lagd_region_decoder
  import lagd_pkg::*;
#(
  parameter int unsigned          NumRules  = RegionNumRules,
  parameter int unsigned          AddrWidth = RegionAddrWidth,
  parameter int unsigned          IdxWidth  = RegionIdxWidth,
  parameter logic [IdxWidth-1:0]  ErrIdx    = '1,
  localparam int unsigned         RuleW     = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [RuleW-1:0]     cfg_rule_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  input  logic                 cfg_lock_i,
  output logic                 locked_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic                 rsp_hit_o,
`ifdef LAGD_REGION_OFFSET_EN
  output logic [AddrWidth-1:0] rsp_offset_o,
`endif
  output logic [15:0]          miss_cnt_o
);

  region_rule_t         r_rules [NumRules];
  logic                 r_locked;
  logic                 r_cfg_err;
  logic                 r_rsp_valid;
  logic [IdxWidth-1:0]  r_rsp_idx;
  logic                 r_rsp_hit;
  logic [15:0]          r_miss_cnt;

  logic                 w_rule_ok;
  logic                 w_bad_enable;
  logic                 w_wr_reject;
  logic                 w_wr_apply;
  logic                 w_accept;
  logic                 w_hit;
  logic [RuleW-1:0]     w_win_num;
  region_rule_t         w_win_rule;
  region_field_e        w_field;
  logic                 w_unused;

  assign w_field      = region_field_e'(cfg_field_i);
  assign w_rule_ok    = 32'(cfg_rule_i) < NumRules;
  assign w_bad_enable = (w_field == RegionFieldEnable) && cfg_wdata_i[0] &&
                        (r_rules[cfg_rule_i].start_addr > r_rules[cfg_rule_i].end_addr);
  assign w_wr_reject  = cfg_we_i && (r_locked || !w_rule_ok || w_bad_enable);
  assign w_wr_apply   = cfg_we_i && !w_wr_reject;

  assign req_ready_o  = !r_rsp_valid || rsp_ready_i;
  assign w_accept     = req_valid_i && req_ready_o;

  // Lookups see the registered table, so a same-cycle write only affects later requests.
  lagd_region_match #(
    .NumRules (NumRules)
  ) u_match (
    .i_rules    (r_rules),
    .i_addr     (RegionAddrWidth'(req_addr_i)),
    .o_hit      (w_hit),
    .o_win_num  (w_win_num),
    .o_win_rule (w_win_rule)
  );

  // NOTE: sequential state is assigned with non-blocking <= only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumRules); i++) r_rules[i] <= '0;
      r_locked  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_wr_reject;
      r_locked  <= r_locked | cfg_lock_i;
      if (w_wr_apply) begin
        unique case (w_field)
          RegionFieldStart:  r_rules[cfg_rule_i].start_addr <= RegionAddrWidth'(cfg_wdata_i);
          RegionFieldEnd:    r_rules[cfg_rule_i].end_addr   <= RegionAddrWidth'(cfg_wdata_i);
          RegionFieldIdx:    r_rules[cfg_rule_i].idx        <= RegionIdxWidth'(cfg_wdata_i[IdxWidth-1:0]);
          RegionFieldEnable: r_rules[cfg_rule_i].en         <= cfg_wdata_i[0];
          default: ;
        endcase
      end
    end
  end

`ifdef LAGD_REGION_OFFSET_EN
  logic [AddrWidth-1:0] r_rsp_offset;
  logic [AddrWidth-1:0] w_offset;

  assign w_offset = w_hit ? AddrWidth'(RegionAddrWidth'(req_addr_i) - w_win_rule.start_addr)
                          : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i)         r_rsp_offset <= '0;
    else if (w_accept) r_rsp_offset <= w_offset;
  end

  assign rsp_offset_o = r_rsp_offset;
`endif

  // Response fields only change on acceptance, which keeps them stable under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_hit   <= 1'b0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_hit   <= w_hit;
        r_rsp_idx   <= w_hit ? IdxWidth'(w_win_rule.idx) : ErrIdx;
        if (!w_hit && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
      end else if (rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign w_unused = ^{w_win_num, w_win_rule.start_addr, w_win_rule.end_addr, w_win_rule.en};

  assign locked_o    = r_locked;
  assign cfg_err_o   = r_cfg_err;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_idx_o   = r_rsp_idx;
  assign rsp_hit_o   = r_rsp_hit;
  assign miss_cnt_o  = r_miss_cnt;

endmodule
